// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control FSM.
// States, opcodes, funct codes, ALU codes and mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_MEMADR = 4'h2,
        S_MEMRD  = 4'h3,
        S_MEMWB  = 4'h4,
        S_MEMWR  = 4'h5,
        S_EXEC   = 4'h6,
        S_ALUWB  = 4'h7,
        S_BRANCH = 4'h8,
        S_ADDIEX = 4'h9,
        S_JUMP   = 4'hA,
        S_ANDIEX = 4'hB,
        S_ORIEX  = 4'hC,
        S_IMMWB  = 4'hD,
        S_RST    = 4'hF
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_OUT = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the FSM and the datapath.
// master = controller, slave = datapath.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero,
        output pc_write, pc_write_cond, pc_en,
        output iord, mem_read, mem_write, ir_write,
        output reg_dst, mem_to_reg, reg_write,
        output alu_src_a, alu_src_b, ext_zero,
        output pc_source, alu_op, illegal_op
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_write, pc_write_cond, pc_en,
        input  iord, mem_read, mem_write, ir_write,
        input  reg_dst, mem_to_reg, reg_write,
        input  alu_src_a, alu_src_b, ext_zero,
        input  pc_source, alu_op, illegal_op
    );
endinterface

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// R-type funct decoder: ALU code plus a supported flag.
// Shared by EXEC and by the DECODE legality check.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic       valid_o
);

    // map funct to ALU code; unknown funct falls back to ADD
    always_comb begin
        alu_op_o = ALU_ADD;
        valid_o  = 1'b1;
        unique case (1'b1)
            (funct_i == FN_ADD): alu_op_o = ALU_ADD;
            (funct_i == FN_SUB): alu_op_o = ALU_SUB;
            (funct_i == FN_AND): alu_op_o = ALU_AND;
            (funct_i == FN_OR):  alu_op_o = ALU_OR;
            default:             valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM.
// Moore strobes per state plus a retired-instruction counter.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_ctrl_if.master        bus,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       fn_op;
    logic             fn_ok;
    logic             retire;

    mc_alu_dec u_alu_dec (
        .funct_i  (bus.funct),
        .alu_op_o (fn_op),
        .valid_o  (fn_ok)
    );

    // state and retired-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state and Moore outputs
    always_comb begin
        state_d           = S_FETCH;
        retire            = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.ext_zero      = 1'b0;
        bus.pc_source     = PCS_ALU;
        bus.alu_op        = ALU_AND;
        bus.illegal_op    = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = 1'b1;
                bus.alu_src_b = SRCB_4;
                bus.alu_op    = ALU_ADD;
                bus.pc_write  = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_BR;
                bus.alu_op    = ALU_ADD;
                unique case (1'b1)
                    (bus.opcode == OP_RTYPE): begin
                        state_d        = fn_ok ? S_EXEC : S_FETCH;
                        bus.illegal_op = !fn_ok;
                    end
                    (bus.opcode == OP_LW),
                    (bus.opcode == OP_SW):   state_d = S_MEMADR;
                    (bus.opcode == OP_BEQ):  state_d = S_BRANCH;
                    (bus.opcode == OP_J):    state_d = S_JUMP;
                    (bus.opcode == OP_ADDI): state_d = S_ADDIEX;
                    (bus.opcode == OP_ANDI): state_d = S_ANDIEX;
                    (bus.opcode == OP_ORI):  state_d = S_ORIEX;
                    default: bus.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALU_ADD;
                state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
                state_d      = S_MEMWB;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                retire         = 1'b1;
            end
            S_MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
                retire        = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = fn_op;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
                retire        = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCS_OUT;
                retire            = 1'b1;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCS_JMP;
                retire        = 1'b1;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALU_ADD;
                state_d       = S_IMMWB;
            end
            S_ANDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.ext_zero  = 1'b1;
                bus.alu_op    = ALU_AND;
                state_d       = S_IMMWB;
            end
            S_ORIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.ext_zero  = 1'b1;
                bus.alu_op    = ALU_OR;
                state_d       = S_IMMWB;
            end
            S_IMMWB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // count only instructions that complete back into FETCH
    always_comb begin
        cnt_d = cnt_q;
        if (retire) cnt_d = cnt_q + CNT_W'(1);
    end

    assign bus.pc_en = bus.pc_write
                     | (bus.pc_write_cond & bus.zero);
    assign state_o     = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm.
// Hand-computed state walks and strobe values per instruction.
module tb_mc_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic [3:0]  state_o;
    logic [31:0] instr_count;
    int          passed;
    int          total;

    mc_ctrl_if bus ();

    mc_ctrl_fsm #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master),
        .state_o     (state_o),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h",
                    tag, obs, exp);
    endtask

    task automatic step(input string tag, input logic [3:0] st);
        @(posedge clk);
        #1;
        chk(tag, 32'(state_o), 32'(st));
    endtask

    task automatic strobes_zero(input string tag);
        chk({tag, "_pcw"}, 32'(bus.pc_write), 32'd0);
        chk({tag, "_mrd"}, 32'(bus.mem_read), 32'd0);
        chk({tag, "_mwr"}, 32'(bus.mem_write), 32'd0);
        chk({tag, "_irw"}, 32'(bus.ir_write), 32'd0);
        chk({tag, "_rgw"}, 32'(bus.reg_write), 32'd0);
        chk({tag, "_aop"}, 32'(bus.alu_op), 32'd0);
        chk({tag, "_pce"}, 32'(bus.pc_en), 32'd0);
    endtask

    logic [5:0] rfn [4];
    logic [2:0] rop [4];

    initial begin
        passed = 0;
        total  = 0;
        rfn[0] = 6'b100000; rop[0] = 3'b010;
        rfn[1] = 6'b100010; rop[1] = 3'b011;
        rfn[2] = 6'b100100; rop[2] = 3'b000;
        rfn[3] = 6'b100101; rop[3] = 3'b001;
        rst_n      = 1'b0;
        bus.opcode = 6'b100011;
        bus.funct  = 6'b0;
        bus.zero   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_o), 32'hF);
        chk("rst_cnt", instr_count, 32'd0);
        strobes_zero("rst");
        rst_n = 1'b1;
        #1;
        chk("rel_state", 32'(state_o), 32'hF);
        strobes_zero("rel");

        step("fetch0", 4'h0);
        chk("f_mrd", 32'(bus.mem_read), 32'd1);
        chk("f_irw", 32'(bus.ir_write), 32'd1);
        chk("f_srcb", 32'(bus.alu_src_b), 32'd1);
        chk("f_aop", 32'(bus.alu_op), 32'd2);
        chk("f_pce", 32'(bus.pc_en), 32'd1);
        chk("f_cnt", instr_count, 32'd0);

        // lw
        step("lw_dec", 4'h1);
        chk("dec_srcb", 32'(bus.alu_src_b), 32'd3);
        chk("dec_ill", 32'(bus.illegal_op), 32'd0);
        step("lw_adr", 4'h2);
        chk("adr_aop", 32'(bus.alu_op), 32'd2);
        chk("adr_srcb", 32'(bus.alu_src_b), 32'd2);
        step("lw_rd", 4'h3);
        chk("rd_iord", 32'(bus.iord), 32'd1);
        chk("rd_mrd", 32'(bus.mem_read), 32'd1);
        step("lw_wb", 4'h4);
        chk("wb_m2r", 32'(bus.mem_to_reg), 32'd1);
        chk("wb_rgw", 32'(bus.reg_write), 32'd1);
        chk("wb_dst", 32'(bus.reg_dst), 32'd0);
        step("lw_end", 4'h0);
        chk("lw_cnt", instr_count, 32'd1);

        // R-type sweep
        bus.opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            bus.funct = rfn[i];
            step("r_dec", 4'h1);
            step("r_exe", 4'h6);
            chk("r_aop", 32'(bus.alu_op), 32'(rop[i]));
            chk("r_srca", 32'(bus.alu_src_a), 32'd1);
            step("r_wb", 4'h7);
            chk("r_dst", 32'(bus.reg_dst), 32'd1);
            chk("r_rgw", 32'(bus.reg_write), 32'd1);
            step("r_end", 4'h0);
        end
        chk("r_cnt", instr_count, 32'd5);

        // beq taken / not taken
        bus.opcode = 6'b000100;
        bus.zero   = 1'b1;
        step("bq1_dec", 4'h1);
        step("bq1_br", 4'h8);
        chk("bq1_pce", 32'(bus.pc_en), 32'd1);
        chk("bq1_pcs", 32'(bus.pc_source), 32'd1);
        chk("bq1_aop", 32'(bus.alu_op), 32'd3);
        step("bq1_end", 4'h0);
        bus.zero = 1'b0;
        step("bq0_dec", 4'h1);
        step("bq0_br", 4'h8);
        chk("bq0_pce", 32'(bus.pc_en), 32'd0);
        chk("bq0_pwc", 32'(bus.pc_write_cond), 32'd1);
        step("bq0_end", 4'h0);
        chk("bq_cnt", instr_count, 32'd7);

        // jump
        bus.opcode = 6'b000010;
        step("j_dec", 4'h1);
        step("j_jmp", 4'hA);
        chk("j_pce", 32'(bus.pc_en), 32'd1);
        chk("j_pcs", 32'(bus.pc_source), 32'd2);
        step("j_end", 4'h0);

        // immediates
        bus.opcode = 6'b001000;
        step("ad_dec", 4'h1);
        step("ad_ex", 4'h9);
        chk("ad_aop", 32'(bus.alu_op), 32'd2);
        chk("ad_ext", 32'(bus.ext_zero), 32'd0);
        step("ad_wb", 4'hD);
        chk("ad_rgw", 32'(bus.reg_write), 32'd1);
        step("ad_end", 4'h0);
        bus.opcode = 6'b001100;
        step("an_dec", 4'h1);
        step("an_ex", 4'hB);
        chk("an_aop", 32'(bus.alu_op), 32'd0);
        chk("an_ext", 32'(bus.ext_zero), 32'd1);
        step("an_wb", 4'hD);
        step("an_end", 4'h0);
        bus.opcode = 6'b001101;
        step("or_dec", 4'h1);
        step("or_ex", 4'hC);
        chk("or_aop", 32'(bus.alu_op), 32'd1);
        chk("or_ext", 32'(bus.ext_zero), 32'd1);
        step("or_wb", 4'hD);
        step("or_end", 4'h0);

        // sw
        bus.opcode = 6'b101011;
        step("sw_dec", 4'h1);
        step("sw_adr", 4'h2);
        step("sw_wr", 4'h5);
        chk("sw_mwr", 32'(bus.mem_write), 32'd1);
        chk("sw_iord", 32'(bus.iord), 32'd1);
        step("sw_end", 4'h0);
        chk("imm_cnt", instr_count, 32'd12);

        // illegal opcode
        bus.opcode = 6'b111111;
        step("io_dec", 4'h1);
        chk("io_ill", 32'(bus.illegal_op), 32'd1);
        step("io_end", 4'h0);
        chk("io_ill0", 32'(bus.illegal_op), 32'd0);
        chk("io_cnt", instr_count, 32'd12);

        // illegal funct
        bus.opcode = 6'b000000;
        bus.funct  = 6'b101010;
        step("if_dec", 4'h1);
        chk("if_ill", 32'(bus.illegal_op), 32'd1);
        step("if_end", 4'h0);
        chk("if_ill0", 32'(bus.illegal_op), 32'd0);
        chk("if_cnt", instr_count, 32'd12);

        // asynchronous reset inside MEMRD
        bus.opcode = 6'b100011;
        step("ar_dec", 4'h1);
        step("ar_adr", 4'h2);
        step("ar_rd", 4'h3);
        chk("ar_mrd1", 32'(bus.mem_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_state", 32'(state_o), 32'hF);
        chk("ar_mrd0", 32'(bus.mem_read), 32'd0);
        chk("ar_cnt", instr_count, 32'd0);
        rst_n = 1'b1;
        step("ar_fetch", 4'h0);
        chk("ar_cnt2", instr_count, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Main control state machine for the multicycle MIPS datapath, sitting directly upstream of the ALU. It sequences fetch/decode/execute/memory/writeback for each instruction and drives the ALU's 3-bit operation code (AND 000, OR 001, ADD 010, SUB 011) plus every datapath mux select and write strobe. Opcode and funct come from the instruction register; zero comes from the ALU.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero (beq)
pc_en  out  1  pc_write | (pc_write_cond & zero)
iord  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  1  write reg: 0=rt, 1=rd
mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=ext imm, 11=sign-ext imm<<2
ext_zero  out  1  immediate extension: 0=sign, 1=zero
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_op  out  3  ALU code driven to the ALU
illegal_op  out  1  one-cycle pulse in DECODE on unsupported opcode/funct
state_o  out  4  current state, debug
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n): when asserted, the state goes to RST (4'hF) and instr_count goes to 0.
- Outputs in RST: all outputs 0, alu_op=000, state_o=4'hF.
- RST always moves to FETCH on the next cycle, so no strobe fires during reset or on the first cycle after it.
- Outputs are Moore, decoded from the state. alu_op in EXEC additionally decodes the held funct value. The IR holds funct stable from DECODE onward.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, JUMP 10, ANDIEX 11, ORIEX 12, IMMWB 13, RST 15. Code 14 is unused and recovers to FETCH.
- Outputs and transitions per state (any output not listed is 0):
  - FETCH: mem_read, ir_write, alu_src_a=0, alu_src_b=01, alu_op=010, pc_source=00, pc_write. Next: DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=010 (branch target computed into ALUOut). Next is selected by opcode:
    - 000000 -> EXEC
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDIEX
    - 001100 (andi) -> ANDIEX
    - 001101 (ori) -> ORIEX
    - anything else -> FETCH with illegal_op=1.
    - R-type with funct outside {100000 add, 100010 sub, 100100 and, 100101 or} -> FETCH with illegal_op=1.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=010. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1, mem_read. Next: MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write. Next: FETCH.
  - MEMWR: iord=1, mem_write. Next: FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct (add 010, sub 011, and 000, or 001). Next: ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=011, pc_write_cond, pc_source=01. Next: FETCH.
  - JUMP: pc_write, pc_source=10. Next: FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, ext_zero=0, alu_op=010. Next: IMMWB.
  - ANDIEX: same as ADDIEX but ext_zero=1, alu_op=000. Next: IMMWB.
  - ORIEX: same as ADDIEX but ext_zero=1, alu_op=001. Next: IMMWB.
  - IMMWB: reg_dst=0, mem_to_reg=0, reg_write. Next: FETCH.
- Latency in cycles: lw 5; sw, R-type, addi/andi/ori 4; beq, j 3; illegal 2.
- alu_op is never 1xx.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or IMMWB. It does not increment on illegal instructions or on RST->FETCH. It wraps modulo 2^CNT_W.
- rst_n asserted mid-instruction: immediate return to RST. Any partially executed instruction is abandoned and not counted.
- pc_en is combinational from pc_write, pc_write_cond and zero. zero is ignored outside BRANCH.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI)
  - funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR)
  - ALU codes (ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=011)
  - alu_src_b and pc_source encodings.
- One combinational sub-module, mc_alu_dec: funct -> {alu_op, valid}. It is used by EXEC and by the DECODE illegal check.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> state_o=F then 0, all strobes 0 until FETCH, instr_count=0.
- lw: opcode=100011 -> states 0,1,2,3,4,0; MEMADR alu_op=010 alu_src_b=10; MEMRD iord=1 mem_read=1; MEMWB mem_to_reg=1 reg_write=1; instr_count=1.
- R-type sweep: funct 100000/100010/100100/100101 -> EXEC alu_op 010/011/000/001; ALUWB reg_dst=1; 4 cycles each; instr_count +4 total.
- beq: zero=1 -> BRANCH pc_en=1, pc_source=01, alu_op=011. Repeat with zero=0 -> pc_en=0. Both retire in 3 cycles.
- Illegal: opcode=111111 -> DECODE illegal_op=1 for exactly 1 cycle, next state FETCH, instr_count unchanged. Repeat with R-type funct=101010 -> same response.
- Mid-op reset: assert rst_n=0 asynchronously while in MEMRD -> state_o=F immediately, mem_read=0 before the next clock edge, instr_count=0.
